// File: rtl/shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : shift_engine
// Brief    : Serial shift/rotate engine, one bit per clock, busy/done handshake.
// Revision : 1.0
// ============================================================================
module shift_engine #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] c_MODE_LOGICAL = 2'b01;
    localparam logic [1:0] c_MODE_ARITH   = 2'b10;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic [WIDTH-1:0] w_step;

    // Single-bit step using the direction/mode captured at start
    always_comb begin
        w_step = r_result;
        if (r_dir) begin
            if (r_mode == c_MODE_LOGICAL || r_mode == c_MODE_ARITH)
                w_step = {r_result[WIDTH-2:0], 1'b0};
            else
                w_step = {r_result[WIDTH-2:0], r_result[WIDTH-1]};
        end else begin
            if (r_mode == c_MODE_LOGICAL)
                w_step = {1'b0, r_result[WIDTH-1:1]};
            else if (r_mode == c_MODE_ARITH)
                w_step = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
            else
                w_step = {r_result[0], r_result[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_count_nxt  = r_count;
        w_dir_nxt    = r_dir;
        w_mode_nxt   = r_mode;
        if (clr) begin
            w_state_nxt  = IDLE;
            w_result_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_result_nxt = load_data;
                        w_count_nxt  = amount;
                        w_dir_nxt    = dir;
                        w_mode_nxt   = mode;
                        w_state_nxt  = (amount != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    w_result_nxt = w_step;
                    w_count_nxt  = r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1))
                        w_state_nxt = DONE;
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_count  <= '0;
            r_dir    <= 1'b0;
            r_mode   <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_count  <= w_count_nxt;
            r_dir    <= w_dir_nxt;
            r_mode   <= w_mode_nxt;
        end
    end

    assign busy   = (r_state == SHIFT) || (r_state == DONE);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: doc/shift_engine.md
Name: shift_engine

Overview:
- Parametrised multi-cycle shift/rotate engine. Successor to the fixed 32-bit rotate-right register.
- Loads a word, then shifts it one bit per clock by a programmed amount. Supports left/right direction and rotate/logical/arithmetic modes.
- Reports progress with a busy/done handshake.
- Sits beside the ALU datapath as a low-area serial shifter for the shift_* exercises.

Parameters:
- WIDTH, 32, data width in bits (>=2)
- CNT_W, 5, width of shift amount; amount range 0..2^CNT_W-1

Ports:
- clock   input   1        rising-edge clock
- reset   input   1        asynchronous, active-high reset
- start   input   1        request; sampled only in IDLE
- clr     input   1        synchronous clear; highest priority after reset
- load_data  input  WIDTH  word loaded on accepted start
- amount  input   CNT_W    number of single-bit steps
- dir     input   1        0 = right (toward bit 0), 1 = left
- mode    input   2        00 rotate, 01 logical, 10 arithmetic, 11 treated as rotate
- busy    output  1        high in SHIFT and DONE states
- done    output  1        one-cycle pulse; result final
- result  output  WIDTH    shift register contents

Behaviour:
- Reset (async, reset=1): state=IDLE, result=0, count=0, busy=0, done=0. Reset may arrive at any time, including mid-shift. On deassertion the block is in IDLE.
- clr=1 at an edge (reset low): result<=0, state<=IDLE, count<=0. This applies in every state and overrides start.
- States: IDLE, SHIFT, DONE. State is encoded in registers. busy and done decode from the state register only.
- IDLE with start=1:
  - result<=load_data, count<=amount.
  - dir and mode are latched into internal registers.
  - Next state is SHIFT if amount!=0, else DONE.
- IDLE with start=0: hold.
- SHIFT, one step per edge, using the latched dir/mode:
  - right rotate: r<={r[0], r[W-1:1]}
  - right logical: r<={0, r[W-1:1]}
  - right arithmetic: r<={r[W-1], r[W-1:1]}
  - left rotate: r<={r[W-2:0], r[W-1]}
  - left logical and left arithmetic: r<={r[W-2:0], 0}
  - After each step count<=count-1. The step taken with count==1 moves the state to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while busy is ignored and causes no queuing. Changes to dir/mode/amount/load_data during SHIFT have no effect.
- Latency: done is high during the cycle following edge number amount+1, counting the start-accepting edge as edge 1.
  - amount=0 gives done one cycle after start with result=load_data.
- result holds its value after DONE until the next accepted start, clr or reset.
- amount >= WIDTH is legal and is executed step by step. Rotate wraps modulo WIDTH. Logical right/left yields 0. Arithmetic right yields all copies of the sign bit.

Test Plan:
- Reset mid-shift: start 0xFFFF0000, right logical, amount 20; assert reset after 5 cycles -> immediately result=0, busy=0, done=0; after release, a new start works normally.
- Rotate right: start 0x80000001, dir=0, mode=00, amount=1 -> done 2 edges after start, result=0xC0000000.
- Left logical and zero amount:
  - start 0x0000000F, dir=1, mode=01, amount=4 -> result=0x000000F0, done pulses exactly one cycle.
  - amount=0 -> done one edge after start, result=0x0000000F.
- Arithmetic right: start 0x80000000, dir=0, mode=10, amount=31 -> result=0xFFFFFFFF. Same stimulus with mode=01 -> result=0x00000001.
- Ignored start and clear:
  - start pulsed again during SHIFT with different load_data -> ignored, original result unchanged.
  - clr asserted in SHIFT -> result=0 and IDLE next edge, no done pulse.
